// File: rtl/netlist_bist_ctrl.sv
// BIST sequencer for the 14-in/8-out mapped netlist: an LFSR drives the inputs,
// a MISR compacts the outputs, and the final signature is compared with a golden value.
module netlist_bist_ctrl #(
  parameter int              IN_W          = 14,
  parameter int              OUT_W         = 8,
  parameter int              NUM_PATTERNS  = 256,
  parameter int              SETTLE_CYCLES = 2,
  parameter logic [IN_W-1:0]  LFSR_SEED     = 14'h0001,
  parameter logic [IN_W-1:0]  LFSR_TAPS     = 14'h2015,
  parameter logic [OUT_W-1:0] MISR_TAPS     = 8'hB8,
  parameter logic [OUT_W-1:0] GOLDEN_SIG    = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] resp,
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      pattern_count
);

  generate
    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_np
      $error("NUM_PATTERNS must be in 1..65535");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [IN_W-1:0] SEED = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   NP = 16'(NUM_PATTERNS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPLY, S_CAPTURE, S_DONE} state_t;

  state_t          state;
  logic [SW-1:0]   settle;
  logic [IN_W-1:0]  lfsr_nxt;
  logic [OUT_W-1:0] sig_nxt;
  logic [15:0]      cnt_nxt;

  assign lfsr_nxt = {stim[IN_W-2:0], ^(stim & LFSR_TAPS)};
  assign sig_nxt  = {signature[OUT_W-2:0], ^(signature & MISR_TAPS)} ^ resp;
  assign cnt_nxt  = pattern_count + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      stim          <= SEED;
      signature     <= '0;
      pattern_count <= '0;
      settle        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (abort && (state == S_LOAD || state == S_APPLY || state == S_CAPTURE)) begin
      // signature and pattern_count stay frozen for post-mortem reads
      state  <= S_IDLE;
      settle <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          stim          <= SEED;
          signature     <= '0;
          pattern_count <= '0;
          settle        <= '0;
          done          <= 1'b0;
          pass          <= 1'b0;
          state         <= S_APPLY;
        end
        S_APPLY: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            state  <= S_CAPTURE;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        S_CAPTURE: begin
          signature     <= sig_nxt;
          pattern_count <= cnt_nxt;
          if (cnt_nxt == NP) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_nxt == GOLDEN_SIG);
          end else begin
            stim  <= lfsr_nxt;
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
